// File: rtl/potato_btn_cond.sv
// Synchronise, debounce and edge-detect the board buttons and mode switch; optional up/down auto-repeat under HOLD_REPEAT_EN.
// Latency: raw change sampled at edge k appears on db/pulse after edge k+1+DEBOUNCE_CYCLES; no backpressure, pulses are fire-and-forget.
module potato_btn_cond #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_center,
   input  logic       sw_mode,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       pressed,
   output logic       mode,
   output logic [4:0] held
);

   localparam int NCH = 6;
   localparam int CW  = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("potato_btn_cond: illegal parameter value");
   end

   // Channel order: 0 up, 1 down, 2 left, 3 right, 4 centre, 5 mode switch.
   logic [NCH-1:0] raw;
   logic [NCH-1:0] meta_q, sync_q;
   logic [NCH-1:0] db_q, db_d;
   logic [CW-1:0]  cnt_q [NCH];
   logic [CW-1:0]  cnt_d [NCH];
   logic [4:0]     rise;
   logic [4:0]     pulse_q, pulse_d;

   assign raw  = {sw_mode, btn_center, btn_right, btn_left, btn_down, btn_up};
   assign rise = db_d[4:0] & ~db_q[4:0];

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         db_d[i]  = db_q[i];
         cnt_d[i] = '0;
         if (sync_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i] = sync_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

`ifdef HOLD_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rc_q [2];
   logic [RW-1:0] rc_d [2];
   logic [1:0]    rep_q, rep_d;
   logic [1:0]    rpt;

   // rep_q marks that the first (long) repeat interval has elapsed.
   always_comb begin
      for (int j = 0; j < 2; j++) begin
         rc_d[j]  = rc_q[j];
         rep_d[j] = rep_q[j];
         rpt[j]   = 1'b0;
         if (!db_d[j] || rise[j]) begin
            rc_d[j]  = '0;
            rep_d[j] = 1'b0;
         end else if (rc_q[j] == (rep_q[j] ? RP_LAST : RD_LAST)) begin
            rpt[j]   = 1'b1;
            rc_d[j]  = '0;
            rep_d[j] = 1'b1;
         end else begin
            rc_d[j] = rc_q[j] + RW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_q <= '0;
         for (int j = 0; j < 2; j++) rc_q[j] <= '0;
      end else begin
         rep_q <= rep_d;
         for (int j = 0; j < 2; j++) rc_q[j] <= rc_d[j];
      end
   end

   assign pulse_d = en ? (rise | {3'b000, rpt}) : '0;
`else
   assign pulse_d = en ? rise : '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q  <= '0;
         sync_q  <= '0;
         db_q    <= '0;
         pulse_q <= '0;
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else begin
         meta_q  <= raw;
         sync_q  <= meta_q;
         db_q    <= db_d;
         pulse_q <= pulse_d;
         for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign up      = pulse_q[0];
   assign down    = pulse_q[1];
   assign left    = pulse_q[2];
   assign right   = pulse_q[3];
   assign pressed = pulse_q[4];
   assign held    = db_q[4:0];
   assign mode    = db_q[5];

endmodule
